// File: rtl/memory_access_if.sv
// Data-memory handshake bundle for the memory stage.
// master: the pipeline side issuing req/we/addr/wdata/be.
// slave : the memory side returning gnt/rvalid/rdata.
interface memory_access_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [3:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/memory_access.sv
// Memory stage of the 5-stage pipeline (execute -> memory -> writeback).
// Issues loads/stores over a req/gnt/rvalid handshake, lane-aligns store data,
// extends load data and registers all results for writeback.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned H/W accesses skip
// the bus and report misaligned_o instead of being force-aligned).
//
// state | meaning
// IDLE  | ready to accept; non-memory ops complete from here in one cycle
// REQ   | dmem request held until gnt
// WAIT  | load granted, waiting for rvalid
// DONE  | results valid for writeback (single cycle)
module memory_access #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2_data_i,
  input  logic              memren_i,
  input  logic              memwen_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        wbsel_i,
  input  logic [4:0]        rd_i,
  input  logic              regwen_i,
  output logic              stall_o,
  memory_access_if.master   dmem,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] alu_res_o,
  output logic [DWIDTH-1:0] memory_data_o,
  output logic [1:0]        wbsel_o,
  output logic [4:0]        rd_o,
  output logic              regwen_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misaligned_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] alu_q;
  logic [DWIDTH-1:0] rs2_q;
  logic              memren_q;
  logic              memwen_q;
  logic [2:0]        f3_q;
  logic [1:0]        wbsel_q;
  logic [4:0]        rd_q;
  logic              regwen_q;

  logic        accept;
  logic        mem_in;
  logic        mis_in;
  logic        size_b_q;
  logic        size_h_q;
  logic [1:0]  eff_a;
  logic [3:0]  be_lane;
  logic [DWIDTH-1:0] wdata_lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [DWIDTH-1:0] ld_ext;
  logic        from_in;
  logic        ld_out;

  assign accept = valid_i && !stall_o;
  assign mem_in = memren_i || memwen_i;

  // funct3[1:0]: 00 byte, 01 half, anything with bit1 set is treated as word.
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_in = mem_in &&
                  (((funct3_i[1:0] == 2'b01) && alu_res_i[0]) ||
                   (funct3_i[1] && (alu_res_i[1:0] != 2'b00)));
`else
  assign mis_in = 1'b0;
`endif

  assign size_b_q = (f3_q[1:0] == 2'b00);
  assign size_h_q = (f3_q[1:0] == 2'b01);
  // Natural alignment of the low address bits; misaligned ops never reach
  // the bus in the trap build, so the same forcing is safe in both builds.
  assign eff_a = size_b_q ? alu_q[1:0] :
                 size_h_q ? {alu_q[1], 1'b0} : 2'b00;

  // Capture the instruction fields on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= '0;
      alu_q    <= '0;
      rs2_q    <= '0;
      memren_q <= 1'b0;
      memwen_q <= 1'b0;
      f3_q     <= '0;
      wbsel_q  <= '0;
      rd_q     <= '0;
      regwen_q <= 1'b0;
    end else if (accept) begin
      pc_q     <= pc_i;
      alu_q    <= alu_res_i;
      rs2_q    <= rs2_data_i;
      memren_q <= memren_i;
      memwen_q <= memwen_i;
      f3_q     <= funct3_i;
      wbsel_q  <= wbsel_i;
      rd_q     <= rd_i;
      regwen_q <= regwen_i;
    end
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_lane    = 4'b1111;
    wdata_lane = rs2_q;
    if (size_b_q) begin
      be_lane    = 4'b0001 << eff_a;
      wdata_lane = {4{rs2_q[7:0]}};
    end else if (size_h_q) begin
      be_lane    = eff_a[1] ? 4'b1100 : 4'b0011;
      wdata_lane = {2{rs2_q[15:0]}};
    end
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    case (eff_a)
      2'd0:    byte_sel = dmem.rdata[7:0];
      2'd1:    byte_sel = dmem.rdata[15:8];
      2'd2:    byte_sel = dmem.rdata[23:16];
      default: byte_sel = dmem.rdata[31:24];
    endcase
    half_sel = eff_a[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    ld_ext   = dmem.rdata;
    if (size_b_q)
      ld_ext = f3_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (size_h_q)
      ld_ext = f3_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && mem_in) state_d = mis_in ? DONE : REQ;
      end
      REQ: begin
        if (dmem.gnt) begin
          if (memwen_q || dmem.rvalid) state_d = DONE;
          else                         state_d = WAIT;
        end
      end
      WAIT: begin
        if (dmem.rvalid) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stall and the bus request, which is only driven in REQ.
  always_comb begin
    stall_o    = (state_q != IDLE);
    dmem.req   = 1'b0;
    dmem.we    = 1'b0;
    dmem.addr  = '0;
    dmem.wdata = '0;
    dmem.be    = 4'b0000;
    if (state_q == REQ) begin
      dmem.req   = 1'b1;
      dmem.we    = memwen_q;
      dmem.addr  = {alu_q[AWIDTH-1:2], 2'b00};
      dmem.wdata = wdata_lane;
      dmem.be    = be_lane;
    end
  end

  // Writeback results load either straight from the inputs (non-memory op
  // or trapped access out of IDLE) or from the captured fields when the
  // access completes.
  assign from_in = (state_q == IDLE);
  assign ld_out  = (from_in && accept && (!mem_in || mis_in)) ||
                   ((state_q == REQ) && dmem.gnt && (memwen_q || dmem.rvalid)) ||
                   ((state_q == WAIT) && dmem.rvalid);

  // Writeback output registers; they hold whenever valid_o is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o       <= 1'b0;
      pc_o          <= '0;
      alu_res_o     <= '0;
      memory_data_o <= '0;
      wbsel_o       <= '0;
      rd_o          <= '0;
      regwen_o      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_o  <= 1'b0;
`endif
    end else begin
      valid_o <= ld_out;
      if (ld_out) begin
        if (from_in) begin
          pc_o          <= pc_i;
          alu_res_o     <= alu_res_i;
          memory_data_o <= '0;
          wbsel_o       <= wbsel_i;
          rd_o          <= rd_i;
          regwen_o      <= regwen_i && !mis_in;
`ifdef MEM_MISALIGN_TRAP_EN
          misaligned_o  <= mis_in;
`endif
        end else begin
          pc_o          <= pc_q;
          alu_res_o     <= alu_q;
          memory_data_o <= memren_q ? ld_ext : '0;
          wbsel_o       <= wbsel_q;
          rd_o          <= rd_q;
          regwen_o      <= regwen_q;
`ifdef MEM_MISALIGN_TRAP_EN
          misaligned_o  <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
